// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU.
//   op_e      - opcode encoding carried on the 3-bit op port
//   state_e   - control FSM states (IDLE, CALC, DONE)
//   FLAG_*    - bit positions of flags inside the packed flag register
//   is_iterative() - true when an op needs the multi-cycle MUL/DIV datapath
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_MUL    = 3'd2,
        OP_DIV    = 3'd3,
        OP_AND    = 3'd4,
        OP_OR     = 3'd5,
        OP_XOR    = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_DZ   = 2;
    localparam int NUM_FLAGS = 3;

    // Divide by zero is answered immediately, so only a real division
    // (and every multiply) takes the iterative path.
    function automatic logic is_iterative(input op_e opc, input logic b_zero);
        return (opc == OP_MUL) || ((opc == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative multiply / divide datapath, one bit per step.
//   clk, rst     - clock, synchronous active-low reset
//   start        - load operands and clear the step counter
//   step         - advance one bit (caller only steps while enabled)
//   is_div       - sampled with start: 1 = restoring divide, 0 = shift-add multiply
//   a, b         - operands sampled with start
//   done         - high during the final step
//   nxt_lo/hi    - value the partial registers take on this step; on the
//                  final step this is the finished result
// MUL: {hi,lo} starts as {0,a}; each step adds b to hi when lo[0] is set and
//      shifts the pair right, leaving the 2*WIDTH product.
// DIV: {hi,lo} starts as {0,a}; each step shifts the next dividend bit into
//      the remainder and keeps the subtraction only if it does not go negative.
//      lo ends as the quotient, hi as the remainder.
module seq_alu_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] nxt_lo,
    output logic [WIDTH-1:0] nxt_hi
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic             div_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        nxt_hi   = '0;
        nxt_lo   = '0;
        if (div_q) begin
            // Top bit of the difference set means the trial subtraction underflowed.
            if (!rem_diff[WIDTH]) begin
                nxt_hi = rem_diff[WIDTH-1:0];
                nxt_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = rem_sh[WIDTH-1:0];
                nxt_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        done = step && (cnt_q == LAST_STEP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            hi_q  <= '0;
            lo_q  <= a;
            b_q   <= b;
            div_q <= is_div;
            cnt_q <= '0;
        end else if (step) begin
            hi_q  <= nxt_hi;
            lo_q  <= nxt_lo;
            cnt_q <= done ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with request/result handshakes.
//   clk, rst            - clock, synchronous active-low reset
//   ena                 - global enable; 0 freezes every register
//   in_valid, in_ready  - request handshake (op, a, b)
//   out_valid, out_ready- result handshake (res_lo, res_hi, flag_*)
//   op                  - 0 ADD 1 SUB 2 MUL 3 DIV 4 AND 5 OR 6 XOR 7 PASS_A
//   res_lo / res_hi     - low result / product high or remainder
//   flag_c, flag_z, flag_dz - carry-or-borrow, zero, divide-by-zero
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE with ena=1; out_valid is 1 only in DONE.
// Requests are never overlapped: in_ready stays 0 in DONE even while the
// result is being taken, so the next request lands the cycle afterwards.
// Results and flags are registered and hold steady until taken.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_dz
);

    state_e state_q, state_d;

    op_e                  opc;
    logic                 b_zero;
    logic                 accept;
    logic                 long_op;
    logic                 md_start;
    logic                 md_step;
    logic                 md_done;
    logic [WIDTH-1:0]     md_lo;
    logic [WIDTH-1:0]     md_hi;
    logic [WIDTH-1:0]     sc_lo;
    logic [WIDTH-1:0]     sc_hi;
    logic [WIDTH:0]       sc_wide;
    logic [NUM_FLAGS-1:0] sc_flags;
    logic [NUM_FLAGS-1:0] md_flags;
    logic [NUM_FLAGS-1:0] flags_q;

    // Single-cycle results, computed straight from the request operands.
    always_comb begin
        opc      = op_e'(op);
        b_zero   = (b == '0);
        long_op  = is_iterative(opc, b_zero);
        sc_lo    = '0;
        sc_hi    = '0;
        sc_wide  = '0;
        sc_flags = '0;
        case (opc)
            OP_ADD: begin
                sc_wide          = {1'b0, a} + {1'b0, b};
                sc_lo            = sc_wide[WIDTH-1:0];
                sc_flags[FLAG_C] = sc_wide[WIDTH];
            end
            OP_SUB: begin
                // The wrapped top bit of the extended difference is the borrow.
                sc_wide          = {1'b0, a} - {1'b0, b};
                sc_lo            = sc_wide[WIDTH-1:0];
                sc_flags[FLAG_C] = sc_wide[WIDTH];
            end
            OP_DIV: begin
                sc_lo             = '1;
                sc_hi             = a;
                sc_flags[FLAG_DZ] = 1'b1;
            end
            OP_AND:    sc_lo = a & b;
            OP_OR:     sc_lo = a | b;
            OP_XOR:    sc_lo = a ^ b;
            OP_PASS_A: sc_lo = a;
            default:   sc_lo = '0;
        endcase
        sc_flags[FLAG_Z] = (sc_lo == '0) && (sc_hi == '0);

        md_flags          = '0;
        md_flags[FLAG_Z]  = (md_lo == '0) && (md_hi == '0);
    end

    // Control FSM: next state and datapath strobes.
    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == ST_IDLE) && ena;
        accept   = in_valid && in_ready;
        md_start = 1'b0;
        md_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    md_start = long_op;
                    state_d  = long_op ? ST_CALC : ST_DONE;
                end
            end
            ST_CALC: begin
                md_step = ena;
                if (md_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (ena && out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            res_lo    <= '0;
            res_hi    <= '0;
            flags_q   <= '0;
        end else if (ena) begin
            state_q <= state_d;
            if (accept && !long_op) begin
                res_lo    <= sc_lo;
                res_hi    <= sc_hi;
                flags_q   <= sc_flags;
                out_valid <= 1'b1;
            end else if (md_done) begin
                res_lo    <= md_lo;
                res_hi    <= md_hi;
                flags_q   <= md_flags;
                out_valid <= 1'b1;
            end else if ((state_q == ST_DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign flag_c  = flags_q[FLAG_C];
    assign flag_z  = flags_q[FLAG_Z];
    assign flag_dz = flags_q[FLAG_DZ];

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .step   (md_step),
        .is_div (opc == OP_DIV),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .nxt_lo (md_lo),
        .nxt_hi (md_hi)
    );

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width (>=4).
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-004 ena  in  1  global enable; 0 freezes all state (FSM, counters, outputs).
REQ-005 in_valid  in  1  operand/op request valid.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 op  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 PASS_A.
REQ-008 a, b  in  WIDTH  operands (unsigned).
REQ-009 out_valid  out  1  result valid.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 res_lo  out  WIDTH  sum/difference/product low/quotient/logic result.
REQ-012 res_hi  out  WIDTH  product high/remainder; 0 for other ops.
REQ-013 flag_c  out  1  ADD carry-out; SUB borrow (a<b); 0 otherwise.
REQ-014 flag_z  out  1  res_lo==0 and res_hi==0.
REQ-015 flag_dz  out  1  DIV with b==0.

Function
REQ-016 FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE with ena=1.
REQ-017 Accept = in_valid & in_ready at rising edge; op, a, b captured at that edge.
REQ-018 ADD, SUB, AND, OR, XOR, PASS_A, and DIV with b==0: IDLE->DONE at accept edge; out_valid visible next cycle (latency 1).
REQ-019 MUL, DIV with b!=0: IDLE->CALC at accept edge; exactly WIDTH CALC steps (one bit per step); CALC->DONE on last step; latency WIDTH+1 cycles.
REQ-020 MUL: shift-add, full 2*WIDTH product {res_hi,res_lo}.
REQ-021 DIV: restoring, res_lo=a/b, res_hi=a%b.
REQ-022 DIV b==0: res_lo=all ones, res_hi=a, flag_dz=1, flag_z=0.
REQ-023 ADD/SUB results modulo 2^WIDTH; carry/borrow in flag_c.
REQ-024 DONE: out_valid=1; res_*/flags held stable until out_ready=1; DONE->IDLE on out_valid&out_ready edge.
REQ-025 No back-to-back overlap: in_ready=0 in DONE even when out_ready=1; next accept earliest the cycle after handshake.
REQ-026 in_valid during CALC/DONE ignored; inputs a, b, op changing during CALC do not affect result.
REQ-027 ena=0 for any number of cycles during CALC: step counter and partials hold; result identical to uninterrupted run, latency extended by stalled cycles.
REQ-028 out_valid, flags, res_* registered outputs; no combinational path from inputs to outputs except in_ready from ena.

Reset
REQ-029 rst=0 at a rising edge: state=IDLE, step counter=0, out_valid=0, res_lo=res_hi=0, flag_c=flag_z=flag_dz=0, regardless of ena.
REQ-030 Reset mid-CALC or mid-DONE aborts operation; result discarded; in_ready=1 the first cycle after rst returns to 1 (ena=1).
REQ-031 Reset takes priority over ena and all handshakes.

Structure
REQ-032 Package seq_alu_pkg: opcode enum/constants, FSM state enum, flag index constants.
REQ-033 Sub-module seq_alu_muldiv: iterative MUL/DIV datapath (start, step, done, WIDTH param); top holds FSM, handshakes, single-cycle ops.
REQ-034 Step counter width $clog2(WIDTH+1); no other parameter hard-coded to 8.

Verification (WIDTH=8)
REQ-035 ADD a=200 b=100, out_ready=1 -> 1 cycle later res_lo=44, res_hi=0, flag_c=1, flag_z=0.
REQ-036 SUB a=5 b=9 -> res_lo=252, flag_c=1; SUB a=9 b=9 -> res_lo=0, flag_z=1, flag_c=0.
REQ-037 MUL a=200 b=100 -> out_valid exactly 9 cycles after accept, res_hi=0x4E, res_lo=0x20.
REQ-038 DIV a=200 b=7 -> res_lo=28, res_hi=4, latency 9; DIV a=13 b=0 -> latency 1, res_lo=255, res_hi=13, flag_dz=1.
REQ-039 MUL with out_ready=0 for 5 cycles then 1, ena=0 for 3 cycles mid-CALC -> outputs stable while waiting, correct product, latency 12, in_ready=0 until cycle after handshake.
REQ-040 DIV accepted, rst=0 at step 4 -> next cycle out_valid=0, all outputs 0, in_ready=1; new ADD 1+1 -> res_lo=2.
